// File: rtl/data_mem_resp.sv
// Single-outstanding load/store responder over a word-organised data array with fixed response latency.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of aligning them.
module data_mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT = 3'(LATENCY);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  cnt_inc_s;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        ready_q, busy_q, resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept_s, enter_resp_s;
  logic        cur_we_s;
  logic [1:0]  cur_size_s;
  logic [31:0] cur_addr_s, cur_wdata_s;
  logic [AW-1:0] idx_s;
  logic [1:0]  lane_s;
  logic        err_s, misalign_s;
  logic [3:0]  be_s;
  logic [31:0] wd_s;
  logic [31:0] word_s, load_s;
  logic        mem_we_s;

  assign accept_s  = req_valid && (state_q == ST_IDLE);
  assign cnt_inc_s = cnt_q + 3'd1;

  // With LATENCY=1 the array is touched on the accepting edge, so bypass the latches then.
  assign cur_we_s    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign cur_size_s  = (state_q == ST_IDLE) ? req_size  : size_q;
  assign cur_addr_s  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign cur_wdata_s = (state_q == ST_IDLE) ? req_wdata : wdata_q;

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_d   = 3'd1;
          state_d = (LAT == 3'd1) ? ST_RESP : ST_WAIT;
        end else begin
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc_s;
        if (cnt_inc_s == LAT) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        cnt_d   = 3'd0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign enter_resp_s = (state_d == ST_RESP) && !reset;

  // Address decode, error detection and lane alignment
  always_comb begin
    idx_s      = cur_addr_s[AW+1:2];
    misalign_s = 1'b0;
    case (cur_size_s)
      2'b01:   lane_s = {cur_addr_s[1], 1'b0};
      2'b10:   lane_s = 2'b00;
      default: lane_s = cur_addr_s[1:0];
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((cur_size_s == 2'b01) && cur_addr_s[0]) begin
      misalign_s = 1'b1;
    end else if ((cur_size_s == 2'b10) && (cur_addr_s[1:0] != 2'b00)) begin
      misalign_s = 1'b1;
    end else begin
      misalign_s = 1'b0;
    end
`endif
    err_s = ((cur_addr_s >> (AW + 2)) != 32'd0) || (cur_size_s == 2'b11) || misalign_s;
  end

  // Byte-enable and store-data replication per access size
  always_comb begin
    case (cur_size_s)
      2'b00: begin
        be_s = 4'b0001 << lane_s;
        wd_s = {4{cur_wdata_s[7:0]}};
      end
      2'b01: begin
        be_s = lane_s[1] ? 4'b1100 : 4'b0011;
        wd_s = {2{cur_wdata_s[15:0]}};
      end
      2'b10: begin
        be_s = 4'b1111;
        wd_s = cur_wdata_s;
      end
      default: begin
        be_s = 4'b0000;
        wd_s = 32'd0;
      end
    endcase
  end

  // Load extraction, right-justified and zero-extended
  always_comb begin
    word_s = mem_q[idx_s];
    case (cur_size_s)
      2'b00:   load_s = (word_s >> {lane_s, 3'b000}) & 32'h0000_00FF;
      2'b01:   load_s = lane_s[1] ? {16'd0, word_s[31:16]} : {16'd0, word_s[15:0]};
      2'b10:   load_s = word_s;
      default: load_s = 32'd0;
    endcase
  end

  assign mem_we_s = enter_resp_s && cur_we_s && !err_s;

  // Array write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
        end
      end
    end
  end

  // Control state, request latches and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      ready_q      <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      resp_valid_q <= enter_resp_s;
      resp_err_q   <= enter_resp_s && err_s;
      resp_rdata_q <= (enter_resp_s && !cur_we_s && !err_s) ? load_s : 32'd0;
    end
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
